// File: rtl/lsu_mem_if.sv
// Load/store unit: turns EX-stage mem_read/mem_write + funct3 into one aligned
// word transaction on a valid/ready request, valid-only response data bus.
module lsu_mem_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic                  lsu_fault,
  output logic [DATA_WIDTH-1:0] mem_out,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_fault;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic [DATA_WIDTH-1:0] r_mem_out;
  logic                  w_access;
  logic                  w_bad;
  logic                  w_busy;
  logic                  w_timeout;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] store_data_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign w_access  = mem_read | mem_write;
  assign w_busy    = (r_state == S_REQ) || (r_state == S_RSP);
  assign w_timeout = w_busy && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Request legality: conflicting strobes, unsupported width codes, misalignment.
  always_comb begin
    w_bad = 1'b0;
    if (mem_read && mem_write)
      w_bad = 1'b1;
    else if (mem_read)
      w_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    else
      w_bad = funct3[2] || (funct3[1:0] == 2'b11);
    if ((funct3[1:0] == 2'b01) && addr[0])
      w_bad = 1'b1;
    if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
      w_bad = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_access) w_next = w_bad ? S_DONE : S_REQ;
      S_REQ:  if (w_timeout) w_next = S_DONE;
              else if (bus_req_ready) w_next = S_RSP;
      S_RSP:  if (w_timeout || bus_rsp_valid) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_stall     = w_busy || ((r_state == S_IDLE) && w_access && !rst);
    lsu_done      = (r_state == S_DONE);
    lsu_fault     = (r_state == S_DONE) && r_fault;
    bus_req_valid = (r_state == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_we      <= 1'b0;
      r_f3      <= 3'd0;
      r_off     <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= 4'd0;
      r_mem_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_access) begin
          r_fault <= w_bad;
          r_cnt   <= '0;
          if (!w_bad) begin
            r_we    <= mem_write;
            r_f3    <= funct3;
            r_off   <= addr[1:0];
            r_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            r_wdata <= mem_write ? store_data_lanes(funct3, store_data) : '0;
            r_wstrb <= mem_write ? store_strobe(funct3, addr[1:0]) : 4'd0;
          end
        end
        S_REQ, S_RSP: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_timeout)
            r_fault <= 1'b1;
          else if ((r_state == S_RSP) && bus_rsp_valid && !r_we)
            r_mem_out <= load_ext(r_f3, r_off, bus_rdata);
        end
        default: r_fault <= 1'b0;
      endcase
    end
  end

  assign mem_out   = r_mem_out;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_wstrb = r_wstrb;

endmodule
